// File: rtl/m_serial_add_ctrl_if.sv
// Bundle of request, result and adder-cell signals for m_serial_add_ctrl.
// master: requesters plus the external 1-bit adder cell. slave: the controller.
// The subtract-select lines exist only when SERIAL_ADD_SUB_EN is defined.
interface m_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             REQ0;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic             REQ1;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             GNT0;
  logic             GNT1;
  logic             BUSY;
  logic             DONE;
  logic             DONE_ID;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             FA_X;
  logic             FA_Y;
  logic             FA_CI;
  logic             FA_S;
  logic             FA_CO;
`ifdef SERIAL_ADD_SUB_EN
  logic             SUB0;
  logic             SUB1;
`endif

  modport master (
    output REQ0, A0, B0, REQ1, A1, B1, FA_S, FA_CO,
    input  GNT0, GNT1, BUSY, DONE, DONE_ID, SUM, COUT, FA_X, FA_Y, FA_CI
`ifdef SERIAL_ADD_SUB_EN
    , output SUB0, SUB1
`endif
  );

  modport slave (
    input  REQ0, A0, B0, REQ1, A1, B1, FA_S, FA_CO,
    output GNT0, GNT1, BUSY, DONE, DONE_ID, SUM, COUT, FA_X, FA_Y, FA_CI
`ifdef SERIAL_ADD_SUB_EN
    , input SUB0, SUB1
`endif
  );
endinterface

// File: rtl/m_serial_add_ctrl.sv
// Bit-serial add sequencer sharing one external combinational full-adder cell
// between two requesters with round-robin arbitration.
// IDLE -> RUN (WIDTH cycles, LSB first) -> DONE (1 cycle) -> IDLE.
// Optional SERIAL_ADD_SUB_EN: per-request SUB bit selects A-B (B inverted, carry-in 1).
module m_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                CLK,
  input logic                RESET,
  m_serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] res_q,     res_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             carry_q,   carry_d;
  logic             cout_q,    cout_d;
  logic             sub_q,     sub_d;
  logic             winner_q,  winner_d;
  logic             last_q,    last_d;
  logic             gnt0_q,    gnt0_d;
  logic             gnt1_q,    gnt1_d;
  logic             done_q,    done_d;
  logic             done_id_q, done_id_d;

  logic run;
  logic pick;
  logic sel_sub;

  assign run = (state_q == ST_RUN);

  // Round-robin winner: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    if (bus.REQ0 && bus.REQ1) pick = ~last_q;
    else                      pick = bus.REQ1;
`ifdef SERIAL_ADD_SUB_EN
    sel_sub = pick ? bus.SUB1 : bus.SUB0;
`else
    sel_sub = 1'b0;
`endif
  end

  // Next-state and datapath: grant/load in IDLE, one serial bit per RUN cycle, publish on the last bit.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    sub_d     = sub_q;
    winner_d  = winner_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          state_d  = ST_RUN;
          winner_d = pick;
          last_d   = pick;
          a_d      = pick ? bus.A1 : bus.A0;
          b_d      = pick ? bus.B1 : bus.B0;
          sub_d    = sel_sub;
          carry_d  = sel_sub;
          cnt_d    = '0;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
        end
      end
      ST_RUN: begin
        carry_d = bus.FA_CO;
        res_d   = {bus.FA_S, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d   = ST_DONE;
          sum_d     = {bus.FA_S, res_q[WIDTH-1:1]};
          cout_d    = bus.FA_CO;
          done_d    = 1'b1;
          done_id_d = winner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; synchronous reset dominates and drops any operation in flight.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (RESET) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      sub_q     <= 1'b0;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      sub_q     <= sub_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.GNT0    = gnt0_q;
  assign bus.GNT1    = gnt1_q;
  assign bus.BUSY    = (state_q != ST_IDLE);
  assign bus.DONE    = done_q;
  assign bus.DONE_ID = done_id_q;
  assign bus.SUM     = sum_q;
  assign bus.COUT    = cout_q;
  // Adder cell inputs are forced low outside RUN; the cell output is used in the same cycle.
  assign bus.FA_X    = run & a_q[0];
  assign bus.FA_Y    = run & (b_q[0] ^ sub_q);
  assign bus.FA_CI   = run & carry_q;

endmodule

// File: tb/tb_m_serial_add_ctrl.sv
// Self-checking bench for m_serial_add_ctrl: table-driven operations, a scoreboard
// filled on each grant and drained on each DONE, and hand sequences for arbitration,
// blocking during RUN, and reset mid-operation.
module tb_m_serial_add_ctrl;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  m_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  m_serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // External adder cell: two half adders plus an OR on the carries.
  logic ha_s, ha_c1, ha_c2;
  assign ha_s       = bus.FA_X ^ bus.FA_Y;
  assign ha_c1      = bus.FA_X & bus.FA_Y;
  assign ha_c2      = ha_s & bus.FA_CI;
  assign bus.FA_S   = ha_s ^ bus.FA_CI;
  assign bus.FA_CO  = ha_c1 | ha_c2;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    int           cyc;
  } exp_t;

  vec_t   vecs[7];
  exp_t   sb[$];
  exp_t   e_push, e_pop;
  logic   gnt_log[$];
  logic [W:0] exp0, exp1;
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // Scoreboard: push on every grant, pop and compare on every DONE.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.GNT0 || bus.GNT1) begin
        check("gnt_onehot", {31'd0, bus.GNT0 & bus.GNT1}, 32'd0);
        check("busy_at_gnt", {31'd0, bus.BUSY}, 32'd1);
        e_push.id   = bus.GNT1;
        e_push.sum  = bus.GNT1 ? exp1[W-1:0] : exp0[W-1:0];
        e_push.cout = bus.GNT1 ? exp1[W] : exp0[W];
        e_push.cyc  = cyc;
        sb.push_back(e_push);
        gnt_log.push_back(bus.GNT1);
      end
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got DONE with empty scoreboard (t=%0t)", $time);
        end else begin
          e_pop = sb.pop_front();
          check("sum", {16'd0, bus.SUM}, {16'd0, e_pop.sum});
          check("cout", {31'd0, bus.COUT}, {31'd0, e_pop.cout});
          check("done_id", {31'd0, bus.DONE_ID}, {31'd0, e_pop.id});
          check("latency", cyc - e_pop.cyc, W);
          check("fa_zero_in_done", {29'd0, bus.FA_X, bus.FA_Y, bus.FA_CI}, 32'd0);
          check("busy_in_done", {31'd0, bus.BUSY}, 32'd1);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(input logic id, output int gc);
    gc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (id ? bus.GNT1 : bus.GNT0) begin
        gc = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL gnt_timeout: got no GNT%0d expected GNT%0d within 80 cycles", id, id);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !bus.BUSY) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL idle_timeout: got %0d pending results expected 0", sb.size());
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W:0] exp);
    int gc;
    drive_edge();
    if (id) begin
      bus.A1 = a; bus.B1 = b; exp1 = exp; bus.REQ1 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      bus.SUB1 = sub;
`endif
    end else begin
      bus.A0 = a; bus.B0 = b; exp0 = exp; bus.REQ0 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      bus.SUB0 = sub;
`endif
    end
    if (sub) begin end
    wait_gnt(id, gc);
    drive_edge();
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    wait_idle();
  endtask

  initial begin
    int g;
    logic [W-1:0] ra, rb;
    vecs[0] = '{1'b0, 16'h1234, 16'h0FF0, 16'h2224, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[6] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0};

    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB0 = 1'b0; bus.SUB1 = 1'b0;
`endif
    exp0 = '0; exp1 = '0;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_outputs",
          {22'd0, bus.GNT0, bus.GNT1, bus.BUSY, bus.DONE, bus.DONE_ID, bus.COUT,
           bus.FA_X, bus.FA_Y, bus.FA_CI, 1'b0}, 32'd0);
    check("rst_sum", {16'd0, bus.SUM}, 32'd0);

    // Both requesters held from reset: grants alternate 0,1,0,1.
    bus.A0 = 16'h0102; bus.B0 = 16'h0304; exp0 = model(16'h0102, 16'h0304, 1'b0);
    bus.A1 = 16'hF000; bus.B1 = 16'h1001; exp1 = model(16'hF000, 16'h1001, 1'b0);
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    drive_edge();
    RESET = 1'b0;
    for (int i = 0; i < 200 && gnt_log.size() < 4; i++) @(negedge CLK);
    drive_edge();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    wait_idle();
    check("rr_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rr_order", (i < gnt_log.size()) ? {31'd0, gnt_log[i]} : 32'hDEAD, i % 2);

    // Table-driven operations.
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, 1'b0, {vecs[i].cout, vecs[i].sum});

    // Random operations against the model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(i[0], ra, rb, 1'b0, model(ra, rb, 1'b0));
    end

    // REQ1 raised in RUN cycle 3 of a requester-0 op waits until after DONE.
    drive_edge();
    bus.A0 = 16'h0010; bus.B0 = 16'h0020; exp0 = model(16'h0010, 16'h0020, 1'b0);
    bus.A1 = 16'h4000; bus.B1 = 16'h4000; exp1 = model(16'h4000, 16'h4000, 1'b0);
    bus.REQ0 = 1'b1;
    wait_gnt(1'b0, g);
    drive_edge();
    bus.REQ0 = 1'b0;
    repeat (2) drive_edge();
    bus.REQ1 = 1'b1;
    begin
      int g1;
      wait_gnt(1'b1, g1);
      check("gnt1_after_idle", g1 - g, W + 2);
    end
    drive_edge();
    bus.REQ1 = 1'b0;
    wait_idle();

    // Reset during RUN cycle 5: operation lost, SUM cleared, no DONE.
    drive_edge();
    bus.A0 = 16'h1234; bus.B0 = 16'h5678; exp0 = model(16'h1234, 16'h5678, 1'b0);
    bus.REQ0 = 1'b1;
    wait_gnt(1'b0, g);
    drive_edge();
    bus.REQ0 = 1'b0;
    repeat (4) drive_edge();
    check("run_cycle5_busy", {31'd0, bus.BUSY}, 32'd1);
    RESET = 1'b1;
    drive_edge();
    RESET = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("rst_mid_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_mid_sum", {16'd0, bus.SUM}, 32'd0);
    check("rst_mid_cout_done", {30'd0, bus.COUT, bus.DONE}, 32'd0);
    begin
      int done_seen = 0;
      for (int i = 0; i < W + 4; i++) begin
        @(negedge CLK);
        if (bus.DONE) done_seen++;
      end
      check("rst_mid_no_done", done_seen, 0);
    end
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, {1'b0, 16'h0100});

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction: COUT=1 means no borrow.
    do_op(1'b0, 16'h0005, 16'h0007, 1'b1, {1'b0, 16'hFFFE});
    do_op(1'b0, 16'h0007, 16'h0005, 1'b1, {1'b1, 16'h0002});
    do_op(1'b1, 16'h0007, 16'h0007, 1'b1, {1'b1, 16'h0000});
`endif

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test expected $finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
